// File: rtl/video_palwriter_if.sv
// CPU-side palette request and shadow readback bus for video_palwriter.
// The master drives requests and readback index; the slave returns ready and readback data.
interface video_palwriter_if;
    logic       req_wr;
    logic [3:0] req_idx;
    logic [5:0] req_data;
    logic       req_rdy;
    logic [3:0] rd_idx;
    logic [5:0] rd_data;

    modport master (
        output req_wr, req_idx, req_data, rd_idx,
        input  req_rdy, rd_data
    );

    modport slave (
        input  req_wr, req_idx, req_data, rd_idx,
        output req_rdy, rd_data
    );
endinterface

// File: rtl/video_palwriter.sv
// Palette write-side controller: queues CPU palette writes and replays them only while
// the beam is blanked, forcing the palette address and keeping a readable shadow copy.
module video_palwriter #(
    parameter int unsigned FIFO_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hblank,
    input  logic             vblank,
    video_palwriter_if.slave cpu,
    output logic             pal_force,
    output logic [3:0]       pal_idx,
    output logic             atm_palwr,
    output logic [5:0]       atm_paldata,
    output logic             busy
);
    localparam int unsigned DEPTH = 1 << FIFO_LOG2;

    typedef logic [FIFO_LOG2-1:0] ptr_t;
    typedef logic [FIFO_LOG2:0]   cnt_t;
    typedef enum logic [1:0] {IDLE, SETUP, WRITE} state_t;

    logic [3:0] fifo_idx_q  [DEPTH];
    logic [5:0] fifo_data_q [DEPTH];
    ptr_t       rd_ptr_q;
    ptr_t       wr_ptr_q;
    ptr_t       rd_ptr_nxt;
    cnt_t       count_q;
    cnt_t       count_d;

    state_t     state_q;
    logic       pal_force_q;
    logic       atm_palwr_q;
    logic [3:0] pal_idx_q;
    logic [5:0] pal_data_q;

    logic [5:0] shadow_q [16];
    logic [5:0] rd_data_q;

    logic       blank;
    logic       rdy;
    logic       push;
    logic       pop;
    logic [3:0] head_idx;
    logic [5:0] head_data;
    logic [3:0] next_idx;
    logic [5:0] next_data;

    always_comb begin
        blank      = hblank | vblank;
        rdy        = (count_q != cnt_t'(DEPTH));
        push       = cpu.req_wr & rdy;
        pop        = (state_q == WRITE);
        rd_ptr_nxt = rd_ptr_q + 1'b1;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end

        // A request pushed this cycle is not in storage yet; forward it when it becomes the head.
        if (count_q != '0) begin
            head_idx  = fifo_idx_q[rd_ptr_q];
            head_data = fifo_data_q[rd_ptr_q];
        end else begin
            head_idx  = cpu.req_idx;
            head_data = cpu.req_data;
        end

        if (count_q > cnt_t'(1)) begin
            next_idx  = fifo_idx_q[rd_ptr_nxt];
            next_data = fifo_data_q[rd_ptr_nxt];
        end else begin
            next_idx  = cpu.req_idx;
            next_data = cpu.req_data;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_idx_q[wr_ptr_q]  <= cpu.req_idx;
            fifo_data_q[wr_ptr_q] <= cpu.req_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_nxt;
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pal_force_q <= 1'b0;
            atm_palwr_q <= 1'b0;
            pal_idx_q   <= '0;
            pal_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (blank && (count_q != '0 || push)) begin
                        state_q     <= SETUP;
                        pal_force_q <= 1'b1;
                        atm_palwr_q <= 1'b0;
                        pal_idx_q   <= head_idx;
                        pal_data_q  <= head_data;
                    end
                end
                SETUP: begin
                    if (blank) begin
                        state_q     <= WRITE;
                        atm_palwr_q <= 1'b1;
                    end else begin
                        // Blank ended before the strobe: leave the entry queued for the next blank.
                        state_q     <= IDLE;
                        pal_force_q <= 1'b0;
                        atm_palwr_q <= 1'b0;
                        pal_idx_q   <= '0;
                        pal_data_q  <= '0;
                    end
                end
                WRITE: begin
                    if (blank && count_d != '0) begin
                        state_q     <= SETUP;
                        pal_force_q <= 1'b1;
                        atm_palwr_q <= 1'b0;
                        pal_idx_q   <= next_idx;
                        pal_data_q  <= next_data;
                    end else begin
                        state_q     <= IDLE;
                        pal_force_q <= 1'b0;
                        atm_palwr_q <= 1'b0;
                        pal_idx_q   <= '0;
                        pal_data_q  <= '0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    pal_force_q <= 1'b0;
                    atm_palwr_q <= 1'b0;
                    pal_idx_q   <= '0;
                    pal_data_q  <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 16; i++) begin
                shadow_q[i] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            if (state_q == WRITE) begin
                shadow_q[pal_idx_q] <= pal_data_q;
            end
            rd_data_q <= shadow_q[cpu.rd_idx];
        end
    end

    assign cpu.req_rdy = rdy;
    assign cpu.rd_data = rd_data_q;
    assign pal_force   = pal_force_q;
    assign pal_idx     = pal_idx_q;
    assign atm_palwr   = atm_palwr_q;
    assign atm_paldata = pal_data_q;
    assign busy        = (count_q != '0) || (state_q != IDLE);
endmodule

// File: tb/tb_video_palwriter.sv
// Self-checking bench for video_palwriter: scoreboard of queued writes against the palette
// write port, plus table-driven request and readback vectors and blank-timing sequences.
module tb_video_palwriter;
    logic clk;
    logic rst;
    logic hblank;
    logic vblank;
    logic pal_force;
    logic [3:0] pal_idx;
    logic atm_palwr;
    logic [5:0] atm_paldata;
    logic busy;

    video_palwriter_if cpu_if ();

    video_palwriter #(.FIFO_LOG2(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .hblank      (hblank),
        .vblank      (vblank),
        .cpu         (cpu_if),
        .pal_force   (pal_force),
        .pal_idx     (pal_idx),
        .atm_palwr   (atm_palwr),
        .atm_paldata (atm_paldata),
        .busy        (busy)
    );

    typedef struct {
        logic [3:0] idx;
        logic [5:0] data;
        logic       rdy;
    } req_vec_t;

    typedef struct {
        logic [3:0] idx;
        logic [5:0] exp;
    } rd_vec_t;

    int n_chk = 0;
    int n_fail = 0;
    int n_writes = 0;
    logic [9:0] sb_q[$];
    logic prev_force = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] idx, input logic [5:0] data, input logic exp_rdy,
                        input string name);
        cpu_if.req_wr   = 1'b1;
        cpu_if.req_idx  = idx;
        cpu_if.req_data = data;
        @(negedge clk);
        chk(name, cpu_if.req_rdy, exp_rdy);
        if (exp_rdy) sb_q.push_back({idx, data});
        tick();
        cpu_if.req_wr = 1'b0;
    endtask

    // Scoreboard: every palette strobe must match the oldest accepted request and follow a forced cycle.
    always @(negedge clk) begin
        if (atm_palwr === 1'b1) begin
            n_writes++;
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_unexpected_write: got idx=%0d data=0x%0h, required no write",
                         pal_idx, atm_paldata);
            end else begin
                chk("sb_write_order", {22'd0, pal_idx, atm_paldata}, {22'd0, sb_q.pop_front()});
            end
            chk("force_leads_palwr", prev_force, 1'b1);
        end
        prev_force = pal_force;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        req_vec_t fill_tbl[5];
        rd_vec_t  rd_tbl[8];
        int w0;

        fill_tbl[0] = '{idx: 4'd1,  data: 6'h05, rdy: 1'b1};
        fill_tbl[1] = '{idx: 4'd2,  data: 6'h0A, rdy: 1'b1};
        fill_tbl[2] = '{idx: 4'd4,  data: 6'h15, rdy: 1'b1};
        fill_tbl[3] = '{idx: 4'd7,  data: 6'h30, rdy: 1'b1};
        fill_tbl[4] = '{idx: 4'd14, data: 6'h3F, rdy: 1'b0};

        rd_tbl[0] = '{idx: 4'd1,  exp: 6'h05};
        rd_tbl[1] = '{idx: 4'd2,  exp: 6'h0A};
        rd_tbl[2] = '{idx: 4'd4,  exp: 6'h15};
        rd_tbl[3] = '{idx: 4'd7,  exp: 6'h30};
        rd_tbl[4] = '{idx: 4'd14, exp: 6'h00};
        rd_tbl[5] = '{idx: 4'd5,  exp: 6'h2A};
        rd_tbl[6] = '{idx: 4'd3,  exp: 6'h11};
        rd_tbl[7] = '{idx: 4'd9,  exp: 6'h3C};

        rst = 1'b1;
        hblank = 1'b0;
        vblank = 1'b0;
        cpu_if.req_wr = 1'b0;
        cpu_if.req_idx = '0;
        cpu_if.req_data = '0;
        cpu_if.rd_idx = '0;

        tick();
        tick();
        @(negedge clk);
        chk("rst_req_rdy", cpu_if.req_rdy, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_pal_force", pal_force, 1'b0);
        chk("rst_atm_palwr", atm_palwr, 1'b0);
        chk("rst_pal_idx", pal_idx, 4'd0);
        chk("rst_atm_paldata", atm_paldata, 6'd0);
        chk("rst_rd_data", cpu_if.rd_data, 6'd0);
        tick();
        rst = 1'b0;

        // Single write with blank held high.
        hblank = 1'b1;
        push(4'd5, 6'h2A, 1'b1, "t1_accept");
        @(negedge clk);
        chk("t1_setup_force", pal_force, 1'b1);
        chk("t1_setup_nowr", atm_palwr, 1'b0);
        chk("t1_setup_idx", pal_idx, 4'd5);
        tick();
        @(negedge clk);
        chk("t1_write_wr", atm_palwr, 1'b1);
        chk("t1_write_idx", pal_idx, 4'd5);
        chk("t1_write_data", atm_paldata, 6'h2A);
        tick();
        hblank = 1'b0;
        cpu_if.rd_idx = 4'd5;
        @(negedge clk);
        chk("t1_busy_done", busy, 1'b0);
        tick();
        @(negedge clk);
        chk("t1_readback", cpu_if.rd_data, 6'h2A);
        tick();

        // Deferred write until vblank.
        push(4'd3, 6'h11, 1'b1, "t2_accept");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t2_no_write", atm_palwr, 1'b0);
            chk("t2_busy", busy, 1'b1);
            tick();
        end
        vblank = 1'b1;
        tick();
        @(negedge clk);
        chk("t2_setup_force", pal_force, 1'b1);
        chk("t2_setup_nowr", atm_palwr, 1'b0);
        chk("t2_setup_idx", pal_idx, 4'd3);
        tick();
        @(negedge clk);
        chk("t2_write_wr", atm_palwr, 1'b1);
        chk("t2_write_idx", pal_idx, 4'd3);
        chk("t2_write_data", atm_paldata, 6'h11);
        tick();
        vblank = 1'b0;
        @(negedge clk);
        chk("t2_busy_done", busy, 1'b0);
        tick();

        // Abort on a one-cycle blank, then retry on a two-cycle blank.
        w0 = n_writes;
        push(4'd9, 6'h3C, 1'b1, "t3_accept");
        tick();
        hblank = 1'b1;
        tick();
        hblank = 1'b0;
        @(negedge clk);
        chk("t3_abort_setup_force", pal_force, 1'b1);
        chk("t3_abort_setup_nowr", atm_palwr, 1'b0);
        tick();
        @(negedge clk);
        chk("t3_abort_idle_force", pal_force, 1'b0);
        chk("t3_abort_kept_busy", busy, 1'b1);
        chk("t3_abort_no_write", n_writes - w0, 0);
        tick();
        hblank = 1'b1;
        tick();
        tick();
        hblank = 1'b0;
        @(negedge clk);
        chk("t3_write_completes", atm_palwr, 1'b1);
        tick();
        @(negedge clk);
        chk("t3_single_write", n_writes - w0, 1);
        chk("t3_busy_done", busy, 1'b0);
        tick();

        // Fill the FIFO while not blanked; the fifth request must be refused.
        w0 = n_writes;
        for (int i = 0; i < 5; i++) begin
            push(fill_tbl[i].idx, fill_tbl[i].data, fill_tbl[i].rdy, "t4_fill_rdy");
        end
        chk("t4_full_busy", busy, 1'b1);
        vblank = 1'b1;
        repeat (9) tick();
        vblank = 1'b0;
        @(negedge clk);
        chk("t4_four_writes_8cyc", n_writes - w0, 4);
        chk("t4_busy_done", busy, 1'b0);

        for (int i = 0; i < 8; i++) begin
            cpu_if.rd_idx = rd_tbl[i].idx;
            tick();
            @(negedge clk);
            chk("t4_readback", {28'd0, rd_tbl[i].idx, 2'b00, cpu_if.rd_data},
                {28'd0, rd_tbl[i].idx, 2'b00, rd_tbl[i].exp});
        end
        tick();

        // Push a fourth entry during a WRITE/pop cycle while draining.
        w0 = n_writes;
        push(4'd8,  6'h21, 1'b1, "t5_accept");
        push(4'd10, 6'h22, 1'b1, "t5_accept");
        push(4'd11, 6'h23, 1'b1, "t5_accept");
        hblank = 1'b1;
        tick();
        tick();
        push(4'd13, 6'h24, 1'b1, "t5_accept_during_pop");
        repeat (6) tick();
        hblank = 1'b0;
        @(negedge clk);
        chk("t5_four_writes_8cyc", n_writes - w0, 4);
        chk("t5_busy_done", busy, 1'b0);
        tick();

        // Reset during WRITE drops the in-flight and queued entries and clears the shadow.
        push(4'd6,  6'h2B, 1'b1, "t6_accept");
        push(4'd12, 6'h19, 1'b1, "t6_accept");
        hblank = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("t6_in_write", atm_palwr, 1'b1);
        tick();
        rst = 1'b0;
        hblank = 1'b0;
        sb_q.delete();
        @(negedge clk);
        chk("t6_post_rst_force", pal_force, 1'b0);
        chk("t6_post_rst_palwr", atm_palwr, 1'b0);
        chk("t6_post_rst_busy", busy, 1'b0);
        chk("t6_post_rst_rdy", cpu_if.req_rdy, 1'b1);
        chk("t6_post_rst_rd_data", cpu_if.rd_data, 6'd0);
        for (int i = 0; i < 16; i++) begin
            cpu_if.rd_idx = 4'(i);
            tick();
            @(negedge clk);
            chk("t6_shadow_cleared", {26'd0, 4'(i), cpu_if.rd_data}, {26'd0, 4'(i), 6'd0});
        end
        tick();
        repeat (3) tick();
        chk("sb_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/video_palwriter.md
# video_palwriter

Write-side controller for the 16-entry video palette. It accepts CPU palette write requests (index, 6-bit colour) through a small FIFO. It replays them into the palette write port only while the beam is blanked, so a write never glitches visible pixels. It forces the palette address to the requested index for the duration of each write and keeps a shadow copy of the palette so the CPU can read colours back. It sits between the CPU port decoder and the frame/palette mixer.

## Interface
- FIFO_LOG2, 2: log2 of request FIFO depth (depth = 4 by default; allowed 1..4).
- clk  in  1  28 MHz video clock.
- rst  in  1  synchronous, active-high reset.
- hblank  in  1  horizontal blank from the raster generator.
- vblank  in  1  vertical blank from the raster generator.
- req_wr  in  1  CPU write strobe, one cycle per request.
- req_idx  in  4  palette index to write.
- req_data  in  6  colour to write.
- req_rdy  out  1  FIFO not full; a request is accepted only when req_wr & req_rdy.
- rd_idx  in  4  shadow readback index.
- rd_data  out  6  shadow palette entry at rd_idx, registered.
- pal_force  out  1  when high, the mixer uses pal_idx as palette address instead of pixel/border colour.
- pal_idx  out  4  forced palette address.
- atm_palwr  out  1  palette RAM write enable.
- atm_paldata  out  6  palette RAM write data.
- busy  out  1  FIFO non-empty or FSM not IDLE.

## Operation
- Blank = hblank | vblank, used combinationally. It is not registered.
- FIFO:
  - Push on req_wr & req_rdy.
  - Pop at the end of a WRITE cycle.
  - When full, req_rdy = 0 and req_wr is ignored, even if a pop happens in the same cycle.
  - A push and a pop in the same cycle on a non-full FIFO keeps the count unchanged.
- FSM states: IDLE, SETUP, WRITE.
  - IDLE → SETUP when the FIFO is non-empty and blank = 1. Otherwise stay in IDLE.
  - SETUP → WRITE when blank = 1.
  - SETUP → IDLE (abort) when blank = 0. The head entry stays in the FIFO, no write occurs, and the entry is retried at the next blank.
  - WRITE → SETUP when the FIFO still holds another entry after the pop and blank = 1. Otherwise WRITE → IDLE.
  - WRITE always completes, even if blank drops during that cycle.
- Outputs by state:
  - pal_force = 1 in SETUP and WRITE. pal_idx and atm_paldata carry the FIFO head index and data in those states.
  - atm_palwr = 1 only in WRITE.
  - In IDLE: pal_force = 0, atm_palwr = 0, pal_idx = 0, atm_paldata = 0.
- Shadow: 16 × 6 registers.
  - shadow[pal_idx] is updated with atm_paldata at the end of each WRITE cycle.
  - rd_data <= shadow[rd_idx] every cycle, with no bypass of a same-cycle update.
- Reset (rst = 1 at a clock edge):
  - FIFO is emptied and the FSM goes to IDLE.
  - All shadow entries are cleared to 0.
  - Outputs from the next cycle: rd_data = 0, req_rdy = 1, busy = 0, and all palette outputs 0.
  - Reset in SETUP or WRITE drops pal_force and atm_palwr the cycle after the reset edge. The in-flight entry is lost.
  - The palette RAM itself is not reset, so the shadow matches it only after software rewrites all 16 entries.

## Timing
- Best-case latency, with a request accepted at edge 0 and blank held high:
  - SETUP occupies cycle 1 and WRITE occupies cycle 2 (atm_palwr high).
  - The shadow update is visible on rd_data at the edge ending cycle 3.
- Back-to-back throughput: one palette write per 2 cycles (SETUP, WRITE, SETUP, WRITE, …).
- pal_force leads atm_palwr by exactly one cycle, so the mixer address is stable before the write strobe.
- A burst of 4 entries needs 8 blank cycles. If blank ends early, the remaining entries wait for the next blank.
- busy falls in the cycle after the final WRITE.
- req_rdy is combinational from the FIFO count and does not depend on req_wr in the same cycle.

## Test plan
- Single write: hblank = 1; push idx 5, data 0x2A → pal_force = 1 in cycle 1, atm_palwr = 1 with pal_idx = 5 and atm_paldata = 0x2A in cycle 2. Then rd_idx = 5 → rd_data = 0x2A, and busy = 0.
- Deferred write: blank = 0; push idx 3, data 0x11 → no atm_palwr and busy = 1 while blank stays low. Raise vblank → SETUP then WRITE with idx 3, data 0x11.
- Abort: blank = 1 for exactly 1 cycle after a push → SETUP then back to IDLE with no atm_palwr. At the next 2-cycle blank the same entry is written once.
- Full FIFO: blank = 0; push 5 requests → the first 4 are accepted, req_rdy = 0 on the 5th, and the 5th is dropped. Raise blank → 4 writes in order over 8 cycles.
- Reset mid-write: assert rst during WRITE → atm_palwr = 0 and pal_force = 0 the next cycle, FIFO empty, every rd_idx returns 0.
- Push while draining: with blank high and 3 entries queued, push a 4th during a WRITE/pop cycle → accepted, and all 4 are written in order with no gap beyond SETUP.
